// File: rtl/data_mem_responder_if.sv
// Request/response bus between the memory stage and the data memory responder.
interface data_mem_responder_if;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic [15:0] data_out;
    logic        stall;
    logic        done;
    logic        err;

    modport master (
        output addr, data_in, rd, wr,
        input  data_out, stall, done, err
    );

    modport slave (
        input  addr, data_in, rd, wr,
        output data_out, stall, done, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: single-port word memory with a fixed access latency.
// One outstanding request. stall is held while busy, and done pulses on completion.
// Optional feature macro: DATA_MEM_ALIGN_CHECK_EN flags odd byte addresses as illegal.
module data_mem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_mem_responder_if.slave   bus
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DW    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [DW-1:0]           wdata_q, wdata_d;
    logic                    op_wr_q, op_wr_d;
    logic [DW-1:0]           data_out_q, data_out_d;
    logic                    stall_q, stall_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    mem_we_c;
    logic                    req_illegal_c;

    logic [DW-1:0]           mem [DEPTH];

`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic unused_addr;
    assign unused_addr   = &{1'b0, bus.addr[DW-1:DEPTH_LOG2+1]};
    assign req_illegal_c = (bus.rd & bus.wr) | ((bus.rd | bus.wr) & bus.addr[0]);
`else
    logic unused_addr;
    assign unused_addr   = &{1'b0, bus.addr[DW-1:DEPTH_LOG2+1], bus.addr[0]};
    assign req_illegal_c = bus.rd & bus.wr;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        op_wr_d    = op_wr_q;
        data_out_d = data_out_q;
        err_d      = 1'b0;
        mem_we_c   = 1'b0;

        case (state_q)
            IDLE: begin
                data_out_d = '0;
                if (req_illegal_c) begin
                    err_d = 1'b1;
                end else if (bus.rd ^ bus.wr) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    idx_d   = bus.addr[DEPTH_LOG2:1];
                    wdata_d = bus.data_in;
                    op_wr_d = bus.wr;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = DONE;
                    if (op_wr_q) begin
                        mem_we_c   = 1'b1;
                        data_out_d = '0;
                    end else begin
                        data_out_d = mem[idx_q];
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                data_out_d = '0;
            end
            default: begin
                state_d    = IDLE;
                data_out_d = '0;
            end
        endcase

        stall_d = (state_d == BUSY);
        done_d  = (state_d == DONE);
    end

    // State, latched request and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            op_wr_q    <= 1'b0;
            data_out_q <= '0;
            stall_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            op_wr_q    <= op_wr_d;
            data_out_q <= data_out_d;
            stall_q    <= stall_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Memory array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.stall    = stall_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (DEPTH_LOG2=10, LATENCY=3).
module tb_data_mem_responder;

    localparam int unsigned LAT = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_LOG2 (10),
        .LATENCY    (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full access: request, LAT stall cycles, one done cycle, return to idle.
    task automatic access(input bit is_wr, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp, input string name);
        @(negedge clk);
        bus.addr    = a;
        bus.data_in = d;
        bus.rd      = !is_wr;
        bus.wr      = is_wr;
        @(negedge clk);
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        bus.addr    = ~a;
        bus.data_in = ~d;
        for (int i = 0; i < int'(LAT); i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (bus.stall !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL %s stall cyc%0d: stall=%b done=%b want stall=1 done=0", name, i, bus.stall, bus.done);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.stall !== 1'b0 || bus.data_out !== (is_wr ? 16'h0000 : exp)) begin
            errors++;
            $display("FAIL %s done: done=%b stall=%b data_out=%h want done=1 stall=0 data_out=%h",
                     name, bus.done, bus.stall, bus.data_out, is_wr ? 16'h0000 : exp);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.stall !== 1'b0 || bus.data_out !== 16'h0000 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: done=%b stall=%b data_out=%h err=%b want 0/0/0000/0",
                     name, bus.done, bus.stall, bus.data_out, bus.err);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.data_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset: stall=%b done=%b err=%b data_out=%h want all 0",
                     bus.stall, bus.done, bus.err, bus.data_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        access(1'b1, 16'h0010, 16'hBEEF, 16'h0000, "wr_0010");
        access(1'b0, 16'h0010, 16'h0000, 16'hBEEF, "rd_0010");
    endtask

    task automatic test_alias();
        access(1'b1, 16'h0004, 16'h1234, 16'h0000, "wr_0004");
        access(1'b0, 16'h0804, 16'h0000, 16'h1234, "rd_0804_alias");
    endtask

    task automatic test_rd_wr_conflict();
        access(1'b1, 16'h0002, 16'h3C3C, 16'h0000, "wr_0002");
        @(negedge clk);
        bus.addr    = 16'h0002;
        bus.data_in = 16'hDEAD;
        bus.rd      = 1'b1;
        bus.wr      = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        checks++;
        if (bus.err !== 1'b1 || bus.stall !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL conflict_err: err=%b stall=%b done=%b want 1/0/0", bus.err, bus.stall, bus.done);
        end
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0 || bus.stall !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL conflict_after: err=%b stall=%b done=%b want 0/0/0", bus.err, bus.stall, bus.done);
        end
        access(1'b0, 16'h0002, 16'h0000, 16'h3C3C, "rd_0002_after_conflict");
    endtask

    task automatic test_ignore_busy();
        int dones;
        access(1'b1, 16'h0006, 16'h6666, 16'h0000, "wr_0006");
        dones = 0;
        @(negedge clk);
        bus.addr = 16'h0006;
        bus.rd   = 1'b1;
        @(negedge clk);
        // first stall cycle: keep presenting rd, it must be ignored
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dones++;
                checks++;
                if (bus.data_out !== 16'h6666) begin
                    errors++;
                    $display("FAIL busy_read_data: data_out=%h want 6666", bus.data_out);
                end
                bus.rd = 1'b1;   // request during DONE is ignored
            end else begin
                bus.rd = 1'b0;
                checks++;
                if (bus.stall !== 1'b0 && i >= 2) begin
                    errors++;
                    $display("FAIL busy_ignored cyc%0d: stall=%b want 0", i, bus.stall);
                end
            end
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL busy_done_count: got %0d want 1", dones);
        end
    endtask

    task automatic test_reset_mid_write();
        access(1'b1, 16'h0020, 16'h5555, 16'h0000, "wr_0020_init");
        @(negedge clk);
        bus.addr    = 16'h0020;
        bus.data_in = 16'hAAAA;
        bus.wr      = 1'b1;
        @(negedge clk);
        bus.wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.done !== 1'b0 || bus.data_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid: stall=%b done=%b data_out=%h want 0/0/0000",
                     bus.stall, bus.done, bus.data_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 16'h0020, 16'h0000, 16'h5555, "rd_0020_after_reset");
    endtask

    task automatic test_align();
`ifdef DATA_MEM_ALIGN_CHECK_EN
        @(negedge clk);
        bus.addr = 16'h0011;
        bus.rd   = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        checks++;
        if (bus.err !== 1'b1 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL align_err: err=%b stall=%b want 1/0", bus.err, bus.stall);
        end
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0 || bus.stall !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL align_after: err=%b stall=%b done=%b want 0/0/0", bus.err, bus.stall, bus.done);
        end
`else
        access(1'b0, 16'h0011, 16'h0000, 16'hBEEF, "rd_0011_odd");
`endif
    endtask

    task automatic test_back_to_back();
        access(1'b1, 16'h07FE, 16'hC0DE, 16'h0000, "wr_07fe");
        access(1'b1, 16'h0000, 16'h0F0F, 16'h0000, "wr_0000");
        access(1'b0, 16'hF7FE, 16'h0000, 16'hC0DE, "rd_f7fe_alias");
        access(1'b0, 16'h0000, 16'h0000, 16'h0F0F, "rd_0000");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_alias();
        test_rd_wr_conflict();
        test_ignore_busy();
        test_reset_mid_write();
        test_align();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
